// File: rtl/quad_frame_sequencer_if.sv
// quad_frame_sequencer_if
//   Bundles the host-side configuration/command handshake and the phase/ADC
//   gating outputs of quad_frame_sequencer.
//   slave  : the sequencer (receives config/commands, drives phases/gates)
//   master : the host/capture side
//   Signals:
//     CFG_VALID/CFG_READY    config handshake, CFG_PERIOD/CFG_OFFSET/CFG_NPER payload
//     CFG_ERR                one-cycle pulse after a rejected config
//     START/ABORT            frame commands (ABORT wins)
//     SIN_PHASE/COS_PHASE    table indices, PHASE_START when SIN_PHASE==0
//     SAMPLE_EN/FRAME_DONE   ADC gate and last-sample marker
//     BUSY/PERIOD_CNT        frame in progress, completed periods in frame
interface quad_frame_sequencer_if #(
  parameter int NPER_W = 16
);
  logic              CFG_VALID;
  logic              CFG_READY;
  logic [7:0]        CFG_PERIOD;
  logic [7:0]        CFG_OFFSET;
  logic [NPER_W-1:0] CFG_NPER;
  logic              CFG_ERR;
  logic              START;
  logic              ABORT;
  logic [7:0]        SIN_PHASE;
  logic [7:0]        COS_PHASE;
  logic              PHASE_START;
  logic              SAMPLE_EN;
  logic              FRAME_DONE;
  logic              BUSY;
  logic [NPER_W-1:0] PERIOD_CNT;

  modport slave (
    input  CFG_VALID, CFG_PERIOD, CFG_OFFSET, CFG_NPER, START, ABORT,
    output CFG_READY, CFG_ERR, SIN_PHASE, COS_PHASE, PHASE_START,
           SAMPLE_EN, FRAME_DONE, BUSY, PERIOD_CNT
  );

  modport master (
    output CFG_VALID, CFG_PERIOD, CFG_OFFSET, CFG_NPER, START, ABORT,
    input  CFG_READY, CFG_ERR, SIN_PHASE, COS_PHASE, PHASE_START,
           SAMPLE_EN, FRAME_DONE, BUSY, PERIOD_CNT
  );
endinterface

// File: rtl/quad_frame_sequencer.sv
// quad_frame_sequencer
//   Free-running quadrature sin/cos phase-index generator with a frame
//   sequencer that aligns an ADC acquisition window to a sine zero crossing
//   and gates SAMPLE_EN for exactly N whole periods.
//   Ports:
//     CLK  sole clock, rising edge
//     RST  synchronous active-high reset
//     bus  quad_frame_sequencer_if.slave (config handshake, commands,
//          phase indices, sample gate, status)
//   Build option:
//     QFS_CONT_EN  defined   -> continuous mode: frames repeat back to back
//                              until ABORT/RST, FRAME_DONE per frame.
//                  undefined -> single-shot: one frame then back to IDLE.
module quad_frame_sequencer #(
  parameter logic [7:0] DEFAULT_PERIOD = 8'd39,
  parameter logic [7:0] DEFAULT_OFFSET = 8'd10,
  parameter int         NPER_W         = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  quad_frame_sequencer_if.slave  bus
);

  localparam logic [NPER_W-1:0] NPER_ONE = {{(NPER_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SYNC, ACQ} state_t;

  state_t            state_q;
  logic [7:0]        sin_q;
  logic [7:0]        cos_q;
  logic [7:0]        period_q;
  logic [NPER_W-1:0] nper_q;
  logic [NPER_W-1:0] pcnt_q;
  logic              cfg_err_q;

  function automatic logic [7:0] phase_next(input logic [7:0] ph, input logic [7:0] tc);
    return (ph == tc) ? 8'd0 : ph + 8'd1;
  endfunction

  logic cfg_fire;
  logic cfg_bad;
  logic sin_tc;
  logic last_period;

  // Config is only taken in IDLE; a bad offset still completes the handshake.
  assign cfg_fire    = bus.CFG_VALID && (state_q == IDLE);
  assign cfg_bad     = bus.CFG_OFFSET > bus.CFG_PERIOD;
  assign sin_tc      = (sin_q == period_q);
  assign last_period = (pcnt_q == (nper_q - NPER_ONE));

  // Phase counters and configuration registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sin_q     <= 8'd0;
      cos_q     <= DEFAULT_OFFSET;
      period_q  <= DEFAULT_PERIOD;
      nper_q    <= NPER_ONE;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_fire && cfg_bad;
      if (cfg_fire && !cfg_bad) begin
        // Restart both counters so cos leads sin by exactly the new offset.
        sin_q    <= 8'd0;
        cos_q    <= bus.CFG_OFFSET;
        period_q <= bus.CFG_PERIOD;
        nper_q   <= (bus.CFG_NPER == '0) ? NPER_ONE : bus.CFG_NPER;
      end else begin
        sin_q <= phase_next(sin_q, period_q);
        cos_q <= phase_next(cos_q, period_q);
      end
    end
  end

  // Frame sequencer. SYNC waits for the sin terminal count so the first
  // ACQ cycle always lands on SIN_PHASE==0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.START && !bus.ABORT) begin
            state_q <= SYNC;
            pcnt_q  <= '0;
          end
        end
        SYNC: begin
          if (bus.ABORT)   state_q <= IDLE;
          else if (sin_tc) state_q <= ACQ;
        end
        ACQ: begin
          if (bus.ABORT) begin
            state_q <= IDLE;
          end else if (sin_tc) begin
            if (last_period) begin
`ifdef QFS_CONT_EN
              pcnt_q <= '0;
`else
              state_q <= IDLE;
              pcnt_q  <= pcnt_q + NPER_ONE;
`endif
            end else begin
              pcnt_q <= pcnt_q + NPER_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CFG_READY   = (state_q == IDLE);
  assign bus.CFG_ERR     = cfg_err_q;
  assign bus.SIN_PHASE   = sin_q;
  assign bus.COS_PHASE   = cos_q;
  assign bus.PHASE_START = (sin_q == 8'd0);
  assign bus.SAMPLE_EN   = (state_q == ACQ);
  assign bus.FRAME_DONE  = (state_q == ACQ) && sin_tc && last_period;
  assign bus.BUSY        = (state_q != IDLE);
  assign bus.PERIOD_CNT  = pcnt_q;

endmodule

// File: tb/tb_quad_frame_sequencer.sv
`timescale 1ns/1ps
module tb_quad_frame_sequencer;
  localparam int NPER_W = 16;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  quad_frame_sequencer_if #(.NPER_W(NPER_W)) bus();

  quad_frame_sequencer #(
    .DEFAULT_PERIOD(8'd39),
    .DEFAULT_OFFSET(8'd10),
    .NPER_W(NPER_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in cycles (cycle e = interval after rising edge e).
  // The phase is pure modular arithmetic from the cycle of the last
  // (re)load; a frame is a window of cycles scheduled when START is taken.
  int e = 0;
  bit mv = 0;
  int mP, mOFF, mN, mref;
  bit mact;
  int mbstart, mastart, maend;
  bit merr;

  function automatic int m_sin(input int c);
    return (c - mref) % (mP + 1);
  endfunction
  function automatic bit m_busy(input int c);
    return mact && (c >= mbstart) && (c <= maend);
  endfunction
  function automatic bit m_acq(input int c);
    return m_busy(c) && (c >= mastart);
  endfunction
  function automatic int m_flen();
    return (mP + 1) * mN;
  endfunction
  function automatic bit m_done(input int c);
    return m_acq(c) && (((c - mastart) % m_flen()) == m_flen() - 1);
  endfunction
  function automatic int m_pcnt(input int c);
    if (c < mastart) return 0;
    return ((c - mastart) % m_flen()) / (mP + 1);
  endfunction

  always @(posedge CLK) begin : model
    bit idle_prev;
    e++;
    if (RST) begin
      mv = 1; mP = 39; mOFF = 10; mN = 1; mref = e; mact = 0; merr = 0;
    end else if (mv) begin
      idle_prev = !m_busy(e - 1);
      merr = 0;
      if (idle_prev && bus.CFG_VALID) begin
        if (bus.CFG_OFFSET > bus.CFG_PERIOD) merr = 1;
        else begin
          mP = int'(bus.CFG_PERIOD); mOFF = int'(bus.CFG_OFFSET);
          mN = (bus.CFG_NPER == 0) ? 1 : int'(bus.CFG_NPER);
          mref = e;
        end
      end
      if (!idle_prev && bus.ABORT) maend = e - 1;
      else if (idle_prev && bus.START && !bus.ABORT) begin
        mact = 1; mbstart = e;
        mastart = e + (mP - m_sin(e)) + 1;
`ifdef QFS_CONT_EN
        maend = 32'h7fffffff;
`else
        maend = mastart + m_flen() - 1;
`endif
      end
    end
    #1;
    if (mv) begin
      chk("sin_phase",   32'(bus.SIN_PHASE),   m_sin(e));
      chk("cos_phase",   32'(bus.COS_PHASE),   (m_sin(e) + mOFF) % (mP + 1));
      chk("phase_start", 32'(bus.PHASE_START), 32'(m_sin(e) == 0));
      chk("sample_en",   32'(bus.SAMPLE_EN),   32'(m_acq(e)));
      chk("frame_done",  32'(bus.FRAME_DONE),  32'(m_done(e)));
      chk("busy",        32'(bus.BUSY),        32'(m_busy(e)));
      chk("cfg_ready",   32'(bus.CFG_READY),   32'(!m_busy(e)));
      chk("cfg_err",     32'(bus.CFG_ERR),     32'(merr));
      if (m_busy(e)) chk("period_cnt", 32'(bus.PERIOD_CNT), m_pcnt(e));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg(input logic [7:0] p, input logic [7:0] o, input logic [NPER_W-1:0] n);
    bus.CFG_VALID = 1'b1; bus.CFG_PERIOD = p; bus.CFG_OFFSET = o; bus.CFG_NPER = n;
    @(negedge CLK);
    bus.CFG_VALID = 1'b0;
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic wait_sin(input logic [7:0] v);
    for (int i = 0; i < 300 && bus.SIN_PHASE != v; i++) @(negedge CLK);
    chk("wait_sin", 32'(bus.SIN_PHASE), 32'(v));
  endtask

  task automatic wait_sample(output int lat);
    lat = 1;
    while (!bus.SAMPLE_EN && lat < 300) begin
      @(negedge CLK);
      lat++;
    end
    chk("sample_reached", 32'(bus.SAMPLE_EN), 1);
  endtask

  task automatic end_frame();
`ifdef QFS_CONT_EN
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
`endif
    for (int i = 0; i < 3000 && bus.BUSY; i++) @(negedge CLK);
    chk("frame_end", 32'(bus.BUSY), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, fd, gaps, s0;
    RST = 1'b1;
    bus.CFG_VALID = 0; bus.CFG_PERIOD = 0; bus.CFG_OFFSET = 0; bus.CFG_NPER = 0;
    bus.START = 0; bus.ABORT = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Reset state and default free-run (cycle 0 after reset).
    chk("rst_sin", 32'(bus.SIN_PHASE), 0);
    chk("rst_cos", 32'(bus.COS_PHASE), 10);
    chk("rst_pstart", 32'(bus.PHASE_START), 1);
    chk("rst_ready", 32'(bus.CFG_READY), 1);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_samp", 32'(bus.SAMPLE_EN), 0);
    chk("rst_done", 32'(bus.FRAME_DONE), 0);
    chk("rst_pcnt", 32'(bus.PERIOD_CNT), 0);
    chk("rst_err", 32'(bus.CFG_ERR), 0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (i == 29) chk("cos_c29", 32'(bus.COS_PHASE), 39);
      if (i == 30) chk("cos_c30", 32'(bus.COS_PHASE), 0);
      if (i == 39) chk("sin_c39", 32'(bus.SIN_PHASE), 39);
      if (i == 40) begin
        chk("sin_c40", 32'(bus.SIN_PHASE), 0);
        chk("pstart_c40", 32'(bus.PHASE_START), 1);
      end
    end

    // Reconfigure: period 7, offset 2, nper 3.
    cfg(8'd7, 8'd2, 16'd3);
    chk("cfg_sin", 32'(bus.SIN_PHASE), 0);
    chk("cfg_cos", 32'(bus.COS_PHASE), 2);
    pulse_start();
    chk("start_busy", 32'(bus.BUSY), 1);
    wait_sample(lat);
    chk("first_samp_sin", 32'(bus.SIN_PHASE), 0);
`ifndef QFS_CONT_EN
    n = 0; fd = 0;
    for (int i = 0; i < 200 && bus.SAMPLE_EN; i++) begin
      n++;
      if (bus.FRAME_DONE) begin
        fd++;
        chk("done_sin", 32'(bus.SIN_PHASE), 7);
        chk("done_pcnt", 32'(bus.PERIOD_CNT), 2);
      end
      @(negedge CLK);
    end
    chk("frame_len", n, 24);
    chk("done_count", fd, 1);
    chk("busy_after_done", 32'(bus.BUSY), 0);
`endif
    end_frame();

    // Back to defaults; START-to-first-sample latency extremes.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    wait_sin(8'd39);
    pulse_start();
    wait_sample(lat);
    chk("lat_max", lat, 41);
    end_frame();
    wait_sin(8'd38);
    pulse_start();
    wait_sample(lat);
    chk("lat_min", lat, 2);
    end_frame();

    // ABORT during the 5th ACQ cycle.
    pulse_start();
    wait_sample(lat);
    repeat (4) @(negedge CLK);
    chk("abort_pre_samp", 32'(bus.SAMPLE_EN), 1);
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    chk("abort_samp", 32'(bus.SAMPLE_EN), 0);
    chk("abort_busy", 32'(bus.BUSY), 0);
    fd = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.FRAME_DONE) fd++;
      @(negedge CLK);
    end
    chk("abort_no_done", fd, 0);
    // START together with ABORT in IDLE.
    bus.START = 1'b1; bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0; bus.ABORT = 1'b0;
    chk("start_abort_busy", 32'(bus.BUSY), 0);
    @(negedge CLK);
    chk("start_abort_busy2", 32'(bus.BUSY), 0);

    // Rejected config: offset 9 > period 5.
    s0 = int'(bus.SIN_PHASE);
    cfg(8'd5, 8'd9, 16'd1);
    chk("rej_err", 32'(bus.CFG_ERR), 1);
    chk("rej_sin", 32'(bus.SIN_PHASE), (s0 + 1) % 40);
    @(negedge CLK);
    chk("rej_err_clr", 32'(bus.CFG_ERR), 0);
    chk("rej_sin2", 32'(bus.SIN_PHASE), (s0 + 2) % 40);

    // Config attempt while in ACQ is not accepted.
    pulse_start();
    wait_sample(lat);
    bus.CFG_VALID = 1'b1; bus.CFG_PERIOD = 8'd5; bus.CFG_OFFSET = 8'd1; bus.CFG_NPER = 16'd1;
    chk("acq_ready", 32'(bus.CFG_READY), 0);
    @(negedge CLK);
    bus.CFG_VALID = 1'b0;
    chk("acq_no_err", 32'(bus.CFG_ERR), 0);
    chk("acq_sin_kept", 32'(bus.SIN_PHASE), 1);
`ifndef QFS_CONT_EN
    n = 1;
    for (int i = 0; i < 200 && bus.SAMPLE_EN; i++) begin
      n++;
      @(negedge CLK);
    end
    chk("acq_cfg_len", n, 40);
`endif
    end_frame();

    // RST mid-frame.
    pulse_start();
    wait_sample(lat);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_busy", 32'(bus.BUSY), 0);
    chk("mid_rst_samp", 32'(bus.SAMPLE_EN), 0);
    chk("mid_rst_sin", 32'(bus.SIN_PHASE), 0);
    chk("mid_rst_cos", 32'(bus.COS_PHASE), 10);
    chk("mid_rst_pcnt", 32'(bus.PERIOD_CNT), 0);

`ifdef QFS_CONT_EN
    // Continuous: period 3, nper 2 -> FRAME_DONE every 8 cycles.
    cfg(8'd3, 8'd1, 16'd2);
    pulse_start();
    wait_sample(lat);
    gaps = 0; fd = 0;
    for (int i = 1; i <= 40; i++) begin
      if (!bus.SAMPLE_EN) gaps++;
      if (bus.FRAME_DONE) begin
        fd++;
        chk("cont_done_pos", i % 8, 0);
      end
      @(negedge CLK);
    end
    chk("cont_gaps", gaps, 0);
    chk("cont_done_cnt", fd, 5);
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    chk("cont_abort_busy", 32'(bus.BUSY), 0);
`else
    gaps = 0;
`endif

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
